compare_pipe: RTL and testbench

COMPARE_PIPE -- requirements
Module: compare_pipe

---
 rtl/compare_pipe.sv | 108 ++++++++++
 tb/tb_compare_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_pipe.sv
// Two-stage valid/ready comparator: stage 1 holds the operands, stage 2 holds the outcome.
// Also counts delivered results that were true, saturating at all-ones.
module compare_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             op_err,
    input  logic             clear_count,
    output logic [CNT_W-1:0] true_count
);

    typedef enum logic [2:0] {
        OP_EQ   = 3'b000,
        OP_NE   = 3'b001,
        OP_RSV2 = 3'b010,
        OP_RSV3 = 3'b011,
        OP_LT   = 3'b100,
        OP_GE   = 3'b101,
        OP_LTU  = 3'b110,
        OP_GEU  = 3'b111
    } op_e;

    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_left;
    logic [WIDTH-1:0] s1_right;

    logic             s2_adv;
    logic             take_in;
    logic             lt_s;
    logic             lt_u;
    logic             cmp_res;
    logic             cmp_err;

    // Stage 1 may refill in the same cycle it drains into stage 2.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign take_in  = in_valid && in_ready;

    always_comb begin
        lt_s    = $signed(s1_left) < $signed(s1_right);
        lt_u    = s1_left < s1_right;
        cmp_res = 1'b0;
        cmp_err = 1'b0;
        case (s1_op)
            OP_EQ:   cmp_res = (s1_left == s1_right);
            OP_NE:   cmp_res = (s1_left != s1_right);
            OP_LT:   cmp_res = lt_s;
            OP_GE:   cmp_res = !lt_s;
            OP_LTU:  cmp_res = lt_u;
            OP_GEU:  cmp_res = !lt_u;
            default: cmp_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_EQ;
            s1_left  <= '0;
            s1_right <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (take_in) begin
                s1_op    <= op_e'(op);
                s1_left  <= left;
                s1_right <= right;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            result    <= 1'b0;
            op_err    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= cmp_res;
                op_err <= cmp_err;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            true_count <= '0;
        end else if (clear_count) begin
            true_count <= '0;
        end else if (out_valid && out_ready && result && (true_count != '1)) begin
            true_count <= true_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_compare_pipe.sv
// Bench for compare_pipe: instance 0 is WIDTH=32/CNT_W=16, instance 1 is WIDTH=8/CNT_W=2.
// Directed vector table and corner sequences, then a random run against a queue scoreboard.
module tb_compare_pipe;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        iv[2];
    logic        ordy[2];
    logic        clr[2];
    logic [2:0]  op[2];
    logic [63:0] lf[2];
    logic [63:0] rt[2];

    logic        a_ir, a_ov, a_res, a_err;
    logic [15:0] a_cnt;
    logic        b_ir, b_ov, b_res, b_err;
    logic [1:0]  b_cnt;

    logic        ir[2], ov[2], res[2], err[2];
    logic [31:0] cnt[2];

    always_comb begin
        ir[0]  = a_ir;  ir[1]  = b_ir;
        ov[0]  = a_ov;  ov[1]  = b_ov;
        res[0] = a_res; res[1] = b_res;
        err[0] = a_err; err[1] = b_err;
        cnt[0] = {16'b0, a_cnt};
        cnt[1] = {30'b0, b_cnt};
    end

    compare_pipe #(.WIDTH(32), .CNT_W(16)) u_a (
        .clk(clk), .resetn(resetn),
        .in_valid(iv[0]), .in_ready(a_ir), .op(op[0]),
        .left(lf[0][31:0]), .right(rt[0][31:0]),
        .out_valid(a_ov), .out_ready(ordy[0]), .result(a_res), .op_err(a_err),
        .clear_count(clr[0]), .true_count(a_cnt)
    );

    compare_pipe #(.WIDTH(8), .CNT_W(2)) u_b (
        .clk(clk), .resetn(resetn),
        .in_valid(iv[1]), .in_ready(b_ir), .op(op[1]),
        .left(lf[1][7:0]), .right(rt[1][7:0]),
        .out_valid(b_ov), .out_ready(ordy[1]), .result(b_res), .op_err(b_err),
        .clear_count(clr[1]), .true_count(b_cnt)
    );

    int checks = 0;
    int errors = 0;
    int wid[2] = '{32, 8};
    int unsigned cmax[2] = '{65535, 3};

    typedef struct {
        logic [2:0]  op;
        logic [63:0] l;
        logic [63:0] r;
        logic        res;
        logic        err;
    } vec_t;
    vec_t vt[13];

    logic [1:0] q0[$];
    logic [1:0] q1[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns {op_err, result} from the operation table, operands read as WIDTH-bit values.
    function automatic logic [1:0] ref_cmp(input logic [2:0] o, input logic [63:0] l,
                                           input logic [63:0] r, input int w);
        logic [63:0] mask, lu, ru;
        longint ls, rs;
        logic lt, ltu;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        lu = l & mask;
        ru = r & mask;
        ls = $signed(lu << (64 - w)) >>> (64 - w);
        rs = $signed(ru << (64 - w)) >>> (64 - w);
        lt  = ls < rs;
        ltu = lu < ru;
        case (o)
            3'd0:    return {1'b0, lu == ru};
            3'd1:    return {1'b0, lu != ru};
            3'd4:    return {1'b0, lt};
            3'd5:    return {1'b0, !lt};
            3'd6:    return {1'b0, ltu};
            3'd7:    return {1'b0, !ltu};
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [63:0] rnd_val(input int w);
        case ($urandom % 6)
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'd1 << (w - 1);
            3:       return (64'd1 << (w - 1)) - 64'd1;
            4:       return 64'($urandom % 4);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One isolated request with out_ready high; returns {op_err, result} of its output.
    task automatic send_one(input int d, input logic [2:0] o, input logic [63:0] l,
                            input logic [63:0] r, input logic clear_on_out,
                            output logic [1:0] got);
        int n;
        op[d] = o; lf[d] = l; rt[d] = r; iv[d] = 1'b1; ordy[d] = 1'b1;
        step();
        iv[d] = 1'b0;
        n = 0;
        while (!ov[d] && n < 8) begin
            step();
            n++;
        end
        chk("single_latency", 64'(n), 64'd1);
        got = {err[d], res[d]};
        clr[d] = clear_on_out;
        step();
        clr[d] = 1'b0;
    endtask

    task automatic push_q(input int d, input logic [1:0] v);
        if (d == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    task automatic pop_q(input int d, output logic [1:0] v, output bit ok);
        ok = 1'b0;
        v  = 2'b00;
        if (d == 0 && q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
        if (d == 1 && q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  got;
        int unsigned exp_a;
        int          acc, j, got_n, k;
        bit          seen;
        logic [1:0]  bexp[3];
        logic [2:0]  bop[3];
        logic [63:0] bl[3], br[3];
        int unsigned mcnt[2];
        bit          hold_v[2];
        logic [1:0]  hold_d[2];
        logic [1:0]  e;
        bit          ok;

        vt[0]  = '{3'b100, 64'h8000_0000, 64'h7FFF_FFFF, 1'b1, 1'b0};
        vt[1]  = '{3'b110, 64'h8000_0000, 64'h7FFF_FFFF, 1'b0, 1'b0};
        vt[2]  = '{3'b101, 64'h5,         64'h5,         1'b1, 1'b0};
        vt[3]  = '{3'b000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0};
        vt[4]  = '{3'b001, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b0};
        vt[5]  = '{3'b010, 64'h1,         64'h2,         1'b0, 1'b1};
        vt[6]  = '{3'b100, 64'hFFFF_FFFF, 64'h0,         1'b1, 1'b0};
        vt[7]  = '{3'b110, 64'hFFFF_FFFF, 64'h0,         1'b0, 1'b0};
        vt[8]  = '{3'b111, 64'hFFFF_FFFF, 64'h0,         1'b1, 1'b0};
        vt[9]  = '{3'b100, 64'h5,         64'h5,         1'b0, 1'b0};
        vt[10] = '{3'b011, 64'h7,         64'h7,         1'b0, 1'b1};
        vt[11] = '{3'b101, 64'h7FFF_FFFF, 64'h8000_0000, 1'b1, 1'b0};
        vt[12] = '{3'b111, 64'h0,         64'h1,         1'b0, 1'b0};

        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; clr[d] = 1'b0;
            op[d] = 3'd0; lf[d] = '0; rt[d] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", 64'(ov[d]), 64'd0);
            chk("rst_result", 64'(res[d]), 64'd0);
            chk("rst_op_err", 64'(err[d]), 64'd0);
            chk("rst_count", 64'(cnt[d]), 64'd0);
            chk("rst_in_ready", 64'(ir[d]), 64'd1);
        end
        resetn = 1'b1;

        // Saturating counter (CNT_W=2), first request on the first edge out of reset
        for (int i = 0; i < 5; i++) begin
            send_one(1, 3'b000, 64'h0, 64'h0, 1'b0, got);
            chk("cnt_result", 64'(got), 64'b01);
            chk("cnt_sat", 64'(cnt[1]), (i < 3) ? 64'(i + 1) : 64'd3);
        end
        send_one(1, 3'b000, 64'h3, 64'h3, 1'b1, got);
        chk("cnt_clear_wins", 64'(cnt[1]), 64'd0);

        // Vector table on the 32-bit instance
        exp_a = 0;
        foreach (vt[i]) begin
            send_one(0, vt[i].op, vt[i].l, vt[i].r, 1'b0, got);
            chk($sformatf("vec%0d", i), 64'(got), 64'({vt[i].err, vt[i].res}));
            if (vt[i].res) exp_a++;
        end
        chk("vec_count", 64'(cnt[0]), 64'(exp_a));

        // Back-to-back stream of 8
        ordy[0] = 1'b1;
        for (k = 0; k < 10; k++) begin
            if (k < 8) begin
                op[0] = 3'b110; lf[0] = 64'(k); rt[0] = 64'd3; iv[0] = 1'b1;
                #1;
                chk("b2b_in_ready", 64'(ir[0]), 64'd1);
            end else begin
                iv[0] = 1'b0;
            end
            step();
            if (k == 0 || k == 9) begin
                chk("b2b_valid_edge", 64'(ov[0]), 64'd0);
            end else begin
                chk("b2b_valid", 64'(ov[0]), 64'd1);
                chk($sformatf("b2b_res%0d", k - 1), 64'({err[0], res[0]}),
                    64'({1'b0, (k - 1) < 3}));
            end
        end
        exp_a += 3;
        chk("b2b_count", 64'(cnt[0]), 64'(exp_a));

        // Backpressure: 5 stalled cycles with in_valid held
        bop[0] = 3'b000; bl[0] = 64'd7;          br[0] = 64'd7;
        bop[1] = 3'b111; bl[1] = 64'd1;          br[1] = 64'd2;
        bop[2] = 3'b001; bl[2] = 64'd3;          br[2] = 64'd4;
        bexp[0] = 2'b01; bexp[1] = 2'b00; bexp[2] = 2'b01;
        ordy[0] = 1'b0; acc = 0; j = 0;
        for (int c = 0; c < 5; c++) begin
            op[0] = bop[j]; lf[0] = bl[j]; rt[0] = br[j]; iv[0] = 1'b1;
            #1;
            if (ir[0]) begin
                acc++;
                if (j < 2) j++;
            end
            step();
            if (c >= 1) chk("bp_hold", 64'({ov[0], err[0], res[0]}), 64'({1'b1, bexp[0]}));
        end
        chk("bp_accepted", 64'(acc), 64'd2);
        #1;
        chk("bp_in_ready", 64'(ir[0]), 64'd0);
        iv[0] = 1'b0; ordy[0] = 1'b1;
        got_n = 0;
        for (int n = 0; n < 10 && got_n < 2; n++) begin
            if (ov[0]) begin
                chk($sformatf("bp_out%0d", got_n), 64'({err[0], res[0]}), 64'(bexp[got_n]));
                got_n++;
            end
            step();
        end
        chk("bp_out_total", 64'(got_n), 64'd2);
        chk("bp_drained", 64'(ov[0]), 64'd0);
        exp_a += 1;
        chk("bp_count", 64'(cnt[0]), 64'(exp_a));

        // Reset with two requests in flight
        ordy[0] = 1'b0;
        op[0] = 3'b000; lf[0] = 64'd9; rt[0] = 64'd9; iv[0] = 1'b1;
        step();
        op[0] = 3'b101; lf[0] = 64'd4; rt[0] = 64'd1;
        step();
        iv[0] = 1'b0;
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(ov[0]), 64'd0);
        chk("mid_rst_count", 64'(cnt[0]), 64'd0);
        chk("mid_rst_in_ready", 64'(ir[0]), 64'd1);
        step();
        resetn = 1'b1;
        ordy[0] = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            step();
            if (ov[0]) seen = 1'b1;
        end
        chk("mid_rst_no_output", 64'(seen), 64'd0);

        // Random traffic on both instances against the scoreboard
        mcnt = '{0, 0};
        hold_v = '{0, 0};
        for (int cyc = 0; cyc < 10010; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                if (hold_v[d])
                    chk("rnd_stall_hold", 64'({ov[d], err[d], res[d]}), 64'({1'b1, hold_d[d]}));
                chk("rnd_count", 64'(cnt[d]), 64'(mcnt[d]));
                if (cyc < 10000) begin
                    iv[d]   = ($urandom % 4) != 0;
                    ordy[d] = ($urandom % 4) != 0;
                    clr[d]  = ($urandom % 64) == 0;
                    op[d]   = 3'($urandom % 8);
                    lf[d]   = rnd_val(wid[d]);
                    rt[d]   = rnd_val(wid[d]);
                end else begin
                    iv[d] = 1'b0; ordy[d] = 1'b1; clr[d] = 1'b0;
                end
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                hold_v[d] = 1'b0;
                if (ov[d] && ordy[d]) begin
                    pop_q(d, e, ok);
                    chk("rnd_unexpected_out", 64'(ok), 64'd1);
                    chk("rnd_result", 64'({err[d], res[d]}), 64'(e));
                    if (!clr[d] && e == 2'b01 && mcnt[d] < cmax[d]) mcnt[d]++;
                end
                if (clr[d]) mcnt[d] = 0;
                if (ov[d] && !ordy[d]) begin
                    hold_v[d] = 1'b1;
                    hold_d[d] = {err[d], res[d]};
                end
                if (iv[d] && ir[d]) push_q(d, ref_cmp(op[d], lf[d], rt[d], wid[d]));
            end
            step();
        end
        chk("rnd_left_in_q0", 64'(q0.size()), 64'd0);
        chk("rnd_left_in_q1", 64'(q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
